// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game-step sequencer.
package snake_pkg;

  localparam int unsigned DEF_TICK_DIV = 1000000;
  localparam int unsigned DEF_GRID_W   = 16;
  localparam int unsigned DEF_GRID_H   = 16;
  localparam int unsigned DEF_MAX_LEN  = 16;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  // Signed unit step; callers sign-extend to the coordinate width so the add wraps.
  function automatic logic signed [1:0] delta_x(input dir_t d);
    case (d)
      DIR_E:   return 2'sb01;
      DIR_W:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  function automatic logic signed [1:0] delta_y(input dir_t d);
    case (d)
      DIR_S:   return 2'sb01;
      DIR_N:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/snake_move_ctrl_tick_gen.sv
// Game-step divider: one-cycle tick every TICK_DIV enabled clocks; holds phase while disabled.
module tick_gen
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game-step sequencer: direction arbitration, wrapping head motion,
// body history shift register and self-collision detection.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter  int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter  int unsigned GRID_W   = DEF_GRID_W,
  parameter  int unsigned GRID_H   = DEF_GRID_H,
  parameter  int unsigned MAX_LEN  = DEF_MAX_LEN,
  localparam int unsigned XW       = $clog2(GRID_W),
  localparam int unsigned YW       = $clog2(GRID_H),
  localparam int unsigned LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          restart,
  input  logic          dir_req_valid,
  input  logic [1:0]    dir_req,
  output logic          dir_req_ready,
  input  logic          grow,
  input  logic [XW-1:0] seg_rd_idx,
  output logic [XW-1:0] seg_rd_x,
  output logic [YW-1:0] seg_rd_y,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic [1:0]    dir,
  output logic          step,
  output logic          dead
);

  localparam int unsigned   IW     = $clog2(MAX_LEN);
  localparam logic [XW-1:0] HOME_X = XW'(GRID_W / 2);
  localparam logic [YW-1:0] HOME_Y = YW'(GRID_H / 2);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  state_t        state, state_nxt;
  dir_t          dir_q, pend_dir, move_dir;
  logic          pend_valid, grow_pend, step_q;
  logic [LW-1:0] len_q, cmp_lim;
  logic [XW-1:0] hist_x [MAX_LEN];
  logic [YW-1:0] hist_y [MAX_LEN];
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [IW-1:0] rd_sel;
  logic          tick, run_en, hit, accept, req_keep, move_ok, reinit;

  assign run_en = enable && (state == ST_RUN);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (run_en),
    .tick(tick)
  );

  assign dir_req_ready = (state != ST_DEAD);
  assign dead          = (state == ST_DEAD);
  assign head_x        = hist_x[0];
  assign head_y        = hist_y[0];
  assign length        = len_q;
  assign dir           = dir_q;
  assign step          = step_q;

  assign accept   = dir_req_valid && dir_req_ready;
  assign req_keep = accept && (dir_t'(dir_req) != opposite(dir_q));
  assign reinit   = (state == ST_DEAD) && restart;
  assign move_ok  = tick && !hit;

  // Prospective move; the collision window excludes the tail cell unless it stays put.
  always_comb begin
    move_dir = pend_valid ? pend_dir : dir_q;
    nx       = hist_x[0] + XW'(delta_x(move_dir));
    ny       = hist_y[0] + YW'(delta_y(move_dir));
    cmp_lim  = grow_pend ? len_q : len_q - 1'b1;
    hit      = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < cmp_lim) && (hist_x[IW'(i)] == nx) && (hist_y[IW'(i)] == ny)) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    rd_sel   = IW'(seg_rd_idx);
    seg_rd_x = hist_x[0];
    seg_rd_y = hist_y[0];
    if (32'(seg_rd_idx) < MAX_LEN) begin
      seg_rd_x = hist_x[rd_sel];
      seg_rd_y = hist_y[rd_sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable)       state_nxt = ST_RUN;
      ST_RUN:  if (tick && hit)  state_nxt = ST_DEAD;
      ST_DEAD: if (restart)      state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= DIR_E;
      pend_dir   <= DIR_E;
      pend_valid <= 1'b0;
      grow_pend  <= 1'b0;
      len_q      <= LW'(1);
      step_q     <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        hist_x[IW'(i)] <= HOME_X;
        hist_y[IW'(i)] <= HOME_Y;
      end
    end else if (reinit) begin
      dir_q      <= DIR_E;
      pend_dir   <= DIR_E;
      pend_valid <= 1'b0;
      grow_pend  <= 1'b0;
      len_q      <= LW'(1);
      step_q     <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        hist_x[IW'(i)] <= HOME_X;
        hist_y[IW'(i)] <= HOME_Y;
      end
    end else begin
      step_q <= move_ok;
      if (move_ok) begin
        dir_q     <= move_dir;
        hist_x[0] <= nx;
        hist_y[0] <= ny;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          hist_x[IW'(i)] <= hist_x[IW'(i - 1)];
          hist_y[IW'(i)] <= hist_y[IW'(i - 1)];
        end
        if (grow_pend && (len_q != LEN_MAX)) begin
          len_q <= len_q + 1'b1;
        end
      end
      // A request or grow landing on the move cycle survives into the next step.
      if (req_keep) begin
        pend_valid <= 1'b1;
        pend_dir   <= dir_t'(dir_req);
      end else if (move_ok) begin
        pend_valid <= 1'b0;
      end
      if (grow && (state != ST_DEAD)) begin
        grow_pend <= 1'b1;
      end else if (move_ok) begin
        grow_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboard bench for snake_move_ctrl with a 4-clock game step on a 16x16 grid.
module tb_snake_move_ctrl;

  logic       clk, rst, enable, restart, dir_req_valid, dir_req_ready, grow, step, dead;
  logic [1:0] dir_req, dir;
  logic [3:0] seg_rd_idx, seg_rd_x, seg_rd_y, head_x, head_y, length;

  typedef struct {
    int x;
    int y;
    int d;
    int len;
    int px;
    int py;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mx, my, md, mlen, mpv, mpd, mg;

  snake_move_ctrl #(
    .TICK_DIV(4),
    .GRID_W  (16),
    .GRID_H  (16),
    .MAX_LEN (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .restart      (restart),
    .dir_req_valid(dir_req_valid),
    .dir_req      (dir_req),
    .dir_req_ready(dir_req_ready),
    .grow         (grow),
    .seg_rd_idx   (seg_rd_idx),
    .seg_rd_x     (seg_rd_x),
    .seg_rd_y     (seg_rd_y),
    .head_x       (head_x),
    .head_y       (head_y),
    .length       (length),
    .dir          (dir),
    .step         (step),
    .dead         (dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 8; my = 8; md = 1; mlen = 1; mpv = 0; mpd = 1; mg = 0;
  endtask

  task automatic send_req(input int d);
    dir_req       = d[1:0];
    dir_req_valid = 1'b1;
    @(negedge clk);
    dir_req_valid = 1'b0;
    if (d != (md ^ 2)) begin
      mpv = 1;
      mpd = d;
    end
  endtask

  task automatic pulse_grow();
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    mg = 1;
  endtask

  task automatic wait_step(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (step) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic expect_move(output int n);
    exp_t e;
    exp_t got;
    bit   ok;
    e.px = mx;
    e.py = my;
    if (mpv != 0) begin
      md  = mpd;
      mpv = 0;
    end
    case (md)
      0:       my = (my + 15) % 16;
      1:       mx = (mx + 1) % 16;
      2:       my = (my + 1) % 16;
      default: mx = (mx + 15) % 16;
    endcase
    if (mg != 0) begin
      if (mlen < 8) mlen++;
      mg = 0;
    end
    e.x = mx; e.y = my; e.d = md; e.len = mlen;
    sb.push_back(e);
    wait_step(n, ok);
    got = sb.pop_front();
    check_eq("step_seen", int'(ok), 1);
    if (ok) begin
      check_eq("head_x", int'(head_x), got.x);
      check_eq("head_y", int'(head_y), got.y);
      check_eq("dir", int'(dir), got.d);
      check_eq("length", int'(length), got.len);
      check_eq("seg1_x", int'(seg_rd_x), got.px);
      check_eq("seg1_y", int'(seg_rd_y), got.py);
    end
  endtask

  initial begin
    int n;
    bit seen, went_dead;
    rst = 1'b1; enable = 1'b0; restart = 1'b0; dir_req_valid = 1'b0;
    dir_req = 2'd0; grow = 1'b0; seg_rd_idx = 4'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_head_x", int'(head_x), 8);
    check_eq("rst_head_y", int'(head_y), 8);
    check_eq("rst_dir", int'(dir), 1);
    check_eq("rst_length", int'(length), 1);
    check_eq("rst_dead", int'(dead), 0);
    check_eq("rst_step", int'(step), 0);
    check_eq("rst_ready", int'(dir_req_ready), 1);

    // Tick period and pause/resume phase
    enable = 1'b1;
    expect_move(n);
    expect_move(n);
    check_eq("tick_period", n, 4);
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (step) seen = 1'b1;
    end
    check_eq("pause_step", int'(seen), 0);
    check_eq("pause_head_x", int'(head_x), mx);
    enable = 1'b1;
    expect_move(n);
    check_eq("resume_phase", n, 2);

    // East wrap, then out-of-range render index reads the head
    repeat (5) expect_move(n);
    check_eq("wrap_x", int'(head_x), 0);
    seg_rd_idx = 4'd11;
    #1;
    check_eq("seg_oob_x", int'(seg_rd_x), mx);
    check_eq("seg_oob_y", int'(seg_rd_y), my);
    seg_rd_idx = 4'd1;

    // Arbitration: reversal discarded, last request wins
    send_req(3);
    expect_move(n);
    check_eq("reverse_dir", int'(dir), 1);
    send_req(2);
    send_req(0);
    expect_move(n);
    check_eq("arb_dir", int'(dir), 0);
    repeat (7) expect_move(n);
    expect_move(n);
    check_eq("wrap_y", int'(head_y), 15);

    // Growth and saturation
    pulse_grow();
    expect_move(n);
    check_eq("grow_len2", int'(length), 2);
    pulse_grow();
    expect_move(n);
    check_eq("grow_len3", int'(length), 3);
    repeat (6) begin
      pulse_grow();
      expect_move(n);
    end
    check_eq("len_sat", int'(length), 8);

    // Collision: fresh snake of length 5 turning a tight square
    enable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst2_head_x", int'(head_x), 8);
    check_eq("rst2_length", int'(length), 1);
    enable = 1'b1;
    repeat (4) begin
      pulse_grow();
      expect_move(n);
    end
    expect_move(n);
    send_req(2);
    expect_move(n);
    send_req(3);
    expect_move(n);
    send_req(0);
    seen = 1'b0;
    went_dead = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (step) seen = 1'b1;
      if (dead) begin
        went_dead = 1'b1;
        break;
      end
    end
    check_eq("coll_dead", int'(went_dead), 1);
    check_eq("coll_no_step", int'(seen), 0);
    check_eq("coll_head_x", int'(head_x), 12);
    check_eq("coll_head_y", int'(head_y), 9);
    check_eq("coll_length", int'(length), 5);
    check_eq("coll_ready", int'(dir_req_ready), 0);

    enable = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_eq("rs_head_x", int'(head_x), 8);
    check_eq("rs_head_y", int'(head_y), 8);
    check_eq("rs_dir", int'(dir), 1);
    check_eq("rs_length", int'(length), 1);
    check_eq("rs_dead", int'(dead), 0);
    check_eq("rs_ready", int'(dir_req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
